// File: rtl/result_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : result_streamer_pkg
// Description : Shared constants and types for the result streamer:
//               section tags carried on out_type, default map sizes,
//               derived spike word count and the FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package result_streamer_pkg;

   // Default map sizes: 14x14 membrane/spike map, 7x7 pooled map.
   localparam int N_V_DEF = 196;
   localparam int N_P_DEF = 49;

   // Number of 16-bit words needed to carry n spike bits.
   function automatic int spike_word_count(input int n);
      return (n + 15) / 16;
   endfunction

   localparam int N_SW_DEF = spike_word_count(N_V_DEF);  // 13

   // Section tags presented on out_type.
   localparam logic [1:0] TYPE_VMEM  = 2'd0;
   localparam logic [1:0] TYPE_SPIKE = 2'd1;
   localparam logic [1:0] TYPE_POOL  = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_VMEM  = 3'd1,
      ST_SPIKE = 3'd2,
      ST_POOL  = 3'd3,
      ST_FIN   = 3'd4
   } rs_state_e;

endpackage
`default_nettype wire

// File: rtl/result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : result_streamer
// Description : Snapshots a membrane vector, a spike vector and a pooled
//               vector on start, then streams them out as one frame of
//               16-bit words over a valid/ready handshake:
//                 N_V membrane words, ceil(N_V/16) packed spike words,
//                 N_P zero-extended pooled words (last one flagged).
//
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset
//               start      - one-cycle frame request (ignored while busy)
//               v_in       - flat membrane vector, N_V x VW (signed)
//               s_in       - spike vector, N_V bits
//               p_in       - flat pooled vector, N_P x PW (unsigned)
//               out_ready  - downstream accepts the current word
//               out_valid  - out_data holds a valid word
//               out_data   - streamed word
//               out_type   - section tag (0 membrane, 1 spike, 2 pooled)
//               out_last   - final word of the frame
//               busy       - frame in progress
//               done       - one-cycle pulse after the final transfer
// Revision    : 1.0 - initial release
// ============================================================================
module result_streamer
   import result_streamer_pkg::*;
#(
   parameter int N_V = N_V_DEF,
   parameter int VW  = 16,
   parameter int N_P = N_P_DEF,
   parameter int PW  = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [N_V*VW-1:0]   v_in,
   input  logic [N_V-1:0]      s_in,
   input  logic [N_P*PW-1:0]   p_in,
   input  logic                out_ready,
   output logic                out_valid,
   output logic [15:0]         out_data,
   output logic [1:0]          out_type,
   output logic                out_last,
   output logic                busy,
   output logic                done
);

   localparam int N_SW = spike_word_count(N_V);
   localparam int SPW  = N_SW * 16;   // spike snapshot padded to whole words

   localparam logic [7:0] LAST_V  = 8'(N_V - 1);
   localparam logic [7:0] LAST_SW = 8'(N_SW - 1);
   localparam logic [7:0] LAST_P  = 8'(N_P - 1);

   rs_state_e          state_q, state_d;
   logic [7:0]         idx_q, idx_d;

   logic [N_V*VW-1:0]  v_snap_q;
   logic [SPW-1:0]     s_snap_q;
   logic [N_P*PW-1:0]  p_snap_q;

   logic               load;
   logic               xfer;

   // -------------------------------------------------------------------------
   // Output decode. Every output is a pure function of state_q, idx_q and the
   // snapshot, so they are stable for the whole cycle and hold automatically
   // while the consumer stalls; an asserted reset forces them all to zero.
   // -------------------------------------------------------------------------
   always_comb begin
      out_valid = 1'b0;
      out_data  = 16'd0;
      out_type  = TYPE_VMEM;
      out_last  = 1'b0;
      busy      = (state_q != ST_IDLE);
      done      = (state_q == ST_FIN);
      case (state_q)
         ST_VMEM: begin
            out_valid = 1'b1;
            out_data  = 16'(v_snap_q[VW*idx_q +: VW]);
            out_type  = TYPE_VMEM;
         end
         ST_SPIKE: begin
            out_valid = 1'b1;
            out_data  = s_snap_q[16*idx_q +: 16];
            out_type  = TYPE_SPIKE;
         end
         ST_POOL: begin
            out_valid = 1'b1;
            out_data  = 16'(p_snap_q[PW*idx_q +: PW]);
            out_type  = TYPE_POOL;
            out_last  = (idx_q == LAST_P);
         end
         default: ;
      endcase
   end

   assign xfer = out_valid & out_ready;

   // -------------------------------------------------------------------------
   // Next-state logic. Section changes happen on the transfer of each
   // section's final word so the next section's first word is presented on
   // the very next cycle.
   // -------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      load    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_VMEM;
               idx_d   = 8'd0;
               load    = 1'b1;
            end
         end
         ST_VMEM: begin
            if (xfer) begin
               if (idx_q == LAST_V) begin
                  state_d = ST_SPIKE;
                  idx_d   = 8'd0;
               end else begin
                  idx_d   = idx_q + 8'd1;
               end
            end
         end
         ST_SPIKE: begin
            if (xfer) begin
               if (idx_q == LAST_SW) begin
                  state_d = ST_POOL;
                  idx_d   = 8'd0;
               end else begin
                  idx_d   = idx_q + 8'd1;
               end
            end
         end
         ST_POOL: begin
            if (xfer) begin
               if (idx_q == LAST_P) begin
                  state_d = ST_FIN;
                  idx_d   = 8'd0;
               end else begin
                  idx_d   = idx_q + 8'd1;
               end
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
            idx_d   = 8'd0;
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // Snapshot is only captured from IDLE and only read inside a frame, so it
   // carries no reset. Spike bits above N_V-1 are zero-filled on capture.
   always_ff @(posedge clk) begin
      if (load) begin
         v_snap_q <= v_in;
         s_snap_q <= SPW'(s_in);
         p_snap_q <= p_in;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_result_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_streamer
// Description : Self-checking bench for result_streamer. A reference model
//               builds the expected word list of each frame from plain
//               arrays; directed frames with fixed and random data and
//               random backpressure are compared word by word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_streamer;

   localparam int N_V   = 196;
   localparam int VW    = 16;
   localparam int N_P   = 49;
   localparam int PW    = 3;
   localparam int N_SW  = 13;
   localparam int FRAME = N_V + N_SW + N_P;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                start;
   logic [N_V*VW-1:0]   v_in;
   logic [N_V-1:0]      s_in;
   logic [N_P*PW-1:0]   p_in;
   logic                out_ready;
   logic                out_valid;
   logic [15:0]         out_data;
   logic [1:0]          out_type;
   logic                out_last;
   logic                busy;
   logic                done;

   always #5 clk = ~clk;

   result_streamer #(.N_V(N_V), .VW(VW), .N_P(N_P), .PW(PW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .v_in      (v_in),
      .s_in      (s_in),
      .p_in      (p_in),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_type  (out_type),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Model data and expected frame
   logic [15:0] m_v [N_V];
   logic        m_s [N_V];
   logic [2:0]  m_p [N_P];
   logic [15:0] e_data [FRAME];
   logic [1:0]  e_type [FRAME];
   logic        e_last [FRAME];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic build_expected();
      int w;
      w = 0;
      for (int k = 0; k < N_V; k++) begin
         e_data[w] = m_v[k]; e_type[w] = 2'd0; e_last[w] = 1'b0; w++;
      end
      for (int j = 0; j < N_SW; j++) begin
         logic [15:0] word;
         word = 16'd0;
         for (int b = 0; b < 16; b++)
            if (16*j + b < N_V) word[b] = m_s[16*j + b];
         e_data[w] = word; e_type[w] = 2'd1; e_last[w] = 1'b0; w++;
      end
      for (int k = 0; k < N_P; k++) begin
         e_data[w] = {13'd0, m_p[k]}; e_type[w] = 2'd2; e_last[w] = (k == N_P-1); w++;
      end
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < N_V; i++) begin
         v_in[VW*i +: VW] = m_v[i];
         s_in[i]          = m_s[i];
      end
      for (int i = 0; i < N_P; i++) p_in[PW*i +: PW] = m_p[i];
   endtask

   task automatic randomize_model(input bit spikes_all_ones);
      for (int i = 0; i < N_V; i++) begin
         m_v[i] = 16'($urandom);
         m_s[i] = spikes_all_ones ? 1'b1 : 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < N_P; i++) m_p[i] = 3'($urandom_range(0, 7));
   endtask

   // Called while positioned at a falling edge with the DUT idle. Pulses
   // start, then follows the frame cycle by cycle. mutate_at: cycle at which
   // new data and a stray start are applied mid-frame (-1 = never).
   // reset_at: word index at which rst_n is pulled low (-1 = never).
   task automatic run_frame(input bit rand_ready, input int mutate_at, input int reset_at);
      int          widx;
      int          cyc;
      bit          stalled;
      bit          fin;
      bit          r;
      logic [15:0] hd;
      logic [1:0]  ht;
      logic        hl;
      build_expected();
      drive_inputs();
      start   = 1'b1;
      widx    = 0;
      cyc     = 0;
      stalled = 1'b0;
      fin     = 1'b0;
      hd = '0; ht = '0; hl = 1'b0;
      while (!fin && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (cyc == mutate_at) begin
            randomize_model(1'b0);
            drive_inputs();
            start = 1'b1;
         end
         r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (widx < FRAME) begin
            if (reset_at >= 0 && widx == reset_at) begin
               #2 rst_n = 1'b0;
               #1;
               check("rst_valid", out_valid, 1'b0);
               check("rst_busy",  busy,      1'b0);
               check("rst_done",  done,      1'b0);
               check("rst_data",  out_data,  16'd0);
               check("rst_type",  out_type,  2'd0);
               check("rst_last",  out_last,  1'b0);
               repeat (3) begin
                  @(negedge clk);
                  check("rst_hold_done",  done,      1'b0);
                  check("rst_hold_valid", out_valid, 1'b0);
               end
               rst_n = 1'b1;
               return;
            end
            check("valid", out_valid, 1'b1);
            check("busy",  busy,      1'b1);
            check("done_early", done, 1'b0);
            if (stalled) begin
               check("hold_data", out_data, hd);
               check("hold_type", out_type, ht);
               check("hold_last", out_last, hl);
            end
            check("data", out_data, e_data[widx]);
            check("type", out_type, e_type[widx]);
            check("last", out_last, e_last[widx]);
            hd = out_data; ht = out_type; hl = out_last;
            stalled   = !r;
            out_ready = r;
            if (r) widx++;
         end else begin
            out_ready = r;
            check("done",      done,      1'b1);
            check("fin_valid", out_valid, 1'b0);
            check("fin_busy",  busy,      1'b1);
            if (!rand_ready) check("done_cycle", cyc, 259);
            fin = 1'b1;
         end
      end
      if (!fin) check("frame_timeout", 32'd0, 32'd1);
      @(negedge clk);
      check("done_pulse", done, 1'b0);
      check("idle_busy",  busy, 1'b0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      out_ready = 1'b0;
      v_in      = '0;
      s_in      = '0;
      p_in      = '0;
      repeat (3) @(negedge clk);
      check("reset_valid", out_valid, 1'b0);
      check("reset_data",  out_data,  16'd0);
      check("reset_type",  out_type,  2'd0);
      check("reset_last",  out_last,  1'b0);
      check("reset_busy",  busy,      1'b0);
      check("reset_done",  done,      1'b0);
      rst_n = 1'b1;
      @(negedge clk);

      // Fixed pattern: ramp membrane, alternating spikes, mod-8 pooled.
      for (int i = 0; i < N_V; i++) begin
         m_v[i] = 16'(i*3 - 100);
         m_s[i] = (i % 2 == 0);
      end
      for (int i = 0; i < N_P; i++) m_p[i] = 3'(i % 8);
      out_ready = 1'b1;
      run_frame(1'b0, -1, -1);

      // Same data under random backpressure.
      run_frame(1'b1, -1, -1);

      // All spikes set: padding bits of the last spike word must stay zero.
      randomize_model(1'b1);
      run_frame(1'b1, -1, -1);

      // Mid-frame input change plus stray start, then an immediate new frame
      // that must carry the changed data.
      randomize_model(1'b0);
      run_frame(1'b0, 60, -1);
      run_frame(1'b1, -1, -1);

      // Reset at word 100, then a full clean frame.
      randomize_model(1'b0);
      run_frame(1'b1, -1, 100);
      @(negedge clk);
      randomize_model(1'b0);
      run_frame(1'b1, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/result_streamer.md
RESULT_STREAMER -- requirements
Module: result_streamer

Interface
REQ-001 Parameter N_V, 196, number of membrane-potential / spike entries (14x14 map).
REQ-002 Parameter VW, 16, membrane word width (signed).
REQ-003 Parameter N_P, 49, number of pooled entries (7x7 map).
REQ-004 Parameter PW, 3, pooled entry width (unsigned).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 start  input  1  one-cycle request to snapshot the inputs and stream them out.
REQ-008 v_in  input  N_V*VW  flat membrane vector; entry i occupies bits [VW*(i+1)-1:VW*i].
REQ-009 s_in  input  N_V  spike vector; entry i is bit i.
REQ-010 p_in  input  N_P*PW  pooled vector; entry i occupies bits [PW*(i+1)-1:PW*i].
REQ-011 out_ready  input  1  downstream ready to accept.
REQ-012 out_valid  output  1  out_data holds a valid word.
REQ-013 out_data  output  16  streamed word.
REQ-014 out_type  output  2  section tag: 0 membrane, 1 spike, 2 pooled.
REQ-015 out_last  output  1  asserted with the final word of a frame.
REQ-016 busy  output  1  frame in progress.
REQ-017 done  output  1  one-cycle pulse after the final word is accepted.

Function
REQ-018 FSM states: IDLE, VMEM, SPIKE, POOL, FIN; reset state IDLE.
REQ-019 In IDLE with start=1: register v_in, s_in, p_in into a snapshot, clear the word index, and go to VMEM; out_valid rises the following cycle (latency 1).
REQ-020 start is ignored whenever busy=1; the snapshot does not change during a frame.
REQ-021 A word transfers on a cycle with out_valid=1 and out_ready=1; the index advances only on a transfer.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_type and out_last hold stable; out_valid never drops without a transfer.
REQ-023 VMEM: words 0..N_V-1 carry membrane entry k unchanged, entry 0 first, out_type=0.
REQ-024 SPIKE: ceil(N_V/16)=13 words; word j bit b = spike entry 16*j+b; bits beyond entry N_V-1 (word 12 bits 15:4) are 0; out_type=1.
REQ-025 POOL: N_P words; entry k zero-extended to 16 bits, entry 0 first; out_type=2.
REQ-026 Frame length 196+13+49=258 words; out_last=1 only on pooled word N_P-1.
REQ-027 Section transitions occur on the transfer of each section's final word, with no bubble cycle.
REQ-028 On the final transfer go to FIN: out_valid=0, done=1 for exactly one cycle, then IDLE.
REQ-029 busy=1 in VMEM, SPIKE, POOL, FIN; 0 in IDLE; a start in the cycle busy falls is accepted.
REQ-030 With out_ready held 1, a frame occupies 258 consecutive valid cycles plus 1 FIN cycle.

Reset
REQ-031 rst_n=0 at any time, including mid-frame, immediately forces IDLE, index 0, out_valid=0, out_last=0, done=0, busy=0, out_data=0, out_type=0; the partial frame is dropped, no done is produced.
REQ-032 Snapshot registers need not be reset; they are never observable outside a frame.

Structure
REQ-033 Shared package holds the section tag constants (0/1/2), the default map sizes (196, 49) and the derived spike word count (13).
REQ-034 Implemented flat in one module; the index counter is 8 bits; word selection is a mux on the snapshot indexed by the counter.

Verification
REQ-035 v_in entry i = i*3-100, s_in = alternating 1/0, p_in entry i = i mod 8, start pulse, out_ready=1 -> 258 words match REQ-023..025, out_last on word 257, done at cycle 259 after start.
REQ-036 Same data, out_ready toggled randomly -> identical word sequence; data stable during every stall.
REQ-037 s_in all ones -> spike words 0..11 = 0xFFFF, word 12 = 0x000F.
REQ-038 start repeated during frame with changed inputs -> output unaffected; start one cycle after done -> second frame carries new data.
REQ-039 rst_n low at word 100 -> out_valid=0 asynchronously, no done; after release new start yields full correct frame from word 0.
